// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector: run-time pattern/length/overlap, registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
`ifdef SEQ_DET_CNT_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic               cfg_err,
`ifdef SEQ_DET_CNT_EN
    output logic [CNT_W-1:0]   match_cnt,
`endif
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0]   MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(3);
    localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(3'b101);

    // The oldest bit falls off on the next shift, so only MAX_LEN-1 bits need storing.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_err;
    logic               r_out;
`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   r_cnt;
`endif

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_eq;
    logic               w_match;
    logic               w_cfg_err;

    always_comb begin
        w_hist_next = {r_hist, in};
        w_fill_inc  = (r_fill == MAX_LEN_W) ? r_fill : r_fill + 1'b1;
        w_eq        = 1'b1;
        // Only the low r_len bits of history and pattern take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < r_len) && (w_hist_next[i] != r_pat[i])) begin
                w_eq = 1'b0;
            end
        end
        w_match   = !r_err && (w_fill_inc >= r_len) && w_eq;
        w_cfg_err = (cfg_len == '0) || (cfg_len > MAX_LEN_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PAT;
            r_len  <= DEF_LEN;
            r_ovl  <= 1'b1;
            r_err  <= 1'b0;
            r_out  <= 1'b0;
        end else if (cfg_load) begin
            // A bit arriving with the load strobe is dropped.
            r_pat  <= cfg_pattern;
            r_len  <= cfg_len;
            r_ovl  <= cfg_overlap;
            r_err  <= w_cfg_err;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (in_valid) begin
            r_hist <= w_hist_next[MAX_LEN-2:0];
            r_out  <= w_match;
            r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
        end else begin
            r_out  <= 1'b0;
        end
    end

`ifdef SEQ_DET_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_cnt <= '0;
        end else if (in_valid && w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`endif

    assign out     = r_out;
    assign cfg_err = r_err;
    assign fill    = r_fill;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a bit-queue reference model predicts every cycle's outputs.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               t_in = 1'b0;
    logic               in_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               out;
    logic               cfg_err;
    logic [LEN_W-1:0]   fill;
`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .LEN_W(LEN_W)
`ifdef SEQ_DET_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(t_in),
        .in_valid(in_valid),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .out(out),
        .cfg_err(cfg_err),
`ifdef SEQ_DET_CNT_EN
        .match_cnt(match_cnt),
`endif
        .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit out;
        bit err;
        int fill;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulse  = 0;

    // Reference model: bits consumed since the last clear, plus the active configuration.
    bit         m_seq[$];
    logic [7:0] m_pat = 8'b101;
    int         m_len = 3;
    bit         m_ovl = 1'b1;
    bit         m_err = 1'b0;
    int         m_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit l,
                        input logic [7:0] p, input int len, input bit o);
        exp_t e;
        bit   m;
        @(negedge clk);
        rst = r; in_valid = v; t_in = b; cfg_load = l;
        cfg_pattern = p; cfg_len = len[3:0]; cfg_overlap = o;
        e.out = 1'b0;
        if (r) begin
            m_seq.delete();
            m_pat = 8'b101; m_len = 3; m_ovl = 1'b1; m_err = 1'b0; m_cnt = 0;
        end else if (l) begin
            m_seq.delete();
            m_pat = p; m_len = len; m_ovl = o; m_cnt = 0;
            m_err = (len == 0) || (len > MAX_LEN);
        end else if (v) begin
            m_seq.push_back(b);
            m = !m_err && (m_seq.size() >= m_len);
            if (m) begin
                for (int k = 0; k < m_len; k++) begin
                    if (m_seq[m_seq.size() - 1 - k] != m_pat[k]) m = 1'b0;
                end
            end
            e.out = m;
            if (m) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) m_seq.delete();
            end
            while (m_seq.size() > MAX_LEN) void'(m_seq.pop_front());
        end
        e.err  = m_err;
        e.fill = (m_seq.size() > MAX_LEN) ? MAX_LEN : m_seq.size();
        e.cnt  = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic bit_in(input bit b);
        step(1'b0, 1'b1, b, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input int len, input bit o);
        step(1'b0, 1'b0, 1'b0, 1'b1, p, len, o);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out", int'(out), int'(e.out));
                chk("cfg_err", int'(cfg_err), int'(e.err));
                chk("fill", int'(fill), e.fill);
`ifdef SEQ_DET_CNT_EN
                chk("match_cnt", int'(match_cnt), e.cnt);
`endif
                if (out) n_pulse++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int base;
        bit r, l, v;
        logic [7:0] seq8;

        // Reset default: "101" overlapping
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        base = n_pulse;
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
        idle();
        chk("pulses_reset_default", n_pulse - base, 2);

        // Non-overlapping
        load(8'b101, 3, 1'b0);
        base = n_pulse;
        for (int i = 0; i < 7; i++) bit_in(~i[0]);
        idle();
        chk("pulses_nonoverlap", n_pulse - base, 2);

        // Long pattern with a two-cycle stall
        load(8'b11010011, 8, 1'b1);
        base = n_pulse;
        seq8 = 8'b11010011;
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq8[i]);
            if (i == 4) begin
                idle(); idle();
            end
        end
        idle();
        chk("pulses_long", n_pulse - base, 1);

        // Illegal lengths, then a legal 2-bit pattern
        load(8'h07, 0, 1'b1);
        base = n_pulse;
        bit_in(1); bit_in(1); bit_in(1);
        idle();
        chk("pulses_len0", n_pulse - base, 0);
        load(8'hff, 9, 1'b1);
        bit_in(1); bit_in(1);
        load(8'b11, 2, 1'b1);
        base = n_pulse;
        bit_in(1); bit_in(1); bit_in(1);
        idle();
        chk("pulses_len2", n_pulse - base, 2);

        // Collisions: load on the completing bit, then reset mid-pattern
        load(8'b101, 3, 1'b1);
        base = n_pulse;
        bit_in(1); bit_in(0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'b101, 3, 1'b1);
        bit_in(1); bit_in(0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        bit_in(1); bit_in(0); bit_in(1);
        idle();
        chk("pulses_collision", n_pulse - base, 1);

        // Length-1 pattern: counter saturation when the counter is built in
        load(8'b1, 1, 1'b1);
        for (int i = 0; i < 5; i++) bit_in(1);
        load(8'b1, 1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 1'($urandom_range(0, 1)), l, 8'($urandom),
                 int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end

        idle(); idle();
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Programmable serial-bit sequence detector for patterns of 1 to MAX_LEN bits.
- Pattern, length and overlap mode are loaded at run time through a configuration strobe.
- Replaces the fixed 3-bit single-pattern detector and sits on the same one-bit serial input path.
- Adds input qualification, a registered one-cycle match pulse, and selectable overlapping or non-overlapping detection.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- LEN_W, 4: width of the length fields; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: match counter width; used only with SEQ_DET_CNT_EN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies `in`; a bit is consumed only on an edge where in_valid=1.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- out  out  1  match pulse, high for exactly one cycle per detected occurrence.
- cfg_err  out  1  high while the latched length is illegal.
- fill  out  LEN_W  number of valid history bits, saturating at MAX_LEN.
- match_cnt  out  CNT_W  count of matches; present only with SEQ_DET_CNT_EN.

Behaviour:
- Reset (rst=1 at an edge):
  - out=0, cfg_err=0, fill=0, history=0, match_cnt=0.
  - Latched config = pattern 'b101, len 3, overlap 1. After reset the block is a "101" overlapping detector with no configuration needed.
  - rst has priority over cfg_load and in_valid. Reset mid-pattern discards all partial history.
- History register:
  - MAX_LEN bits. On a consumed bit: hist <= {hist[MAX_LEN-2:0], in}, so hist[0] is the newest bit.
  - fill increments by 1 per consumed bit, saturating at MAX_LEN.
- Match condition, evaluated on the updated history:
  - The latched len L is legal (1 ≤ L ≤ MAX_LEN).
  - fill_next ≥ L.
  - hist_next[L-1:0] equals pattern[L-1:0]. Bits above L-1 are ignored in both operands.
- Output timing:
  - out is registered. It goes high in the cycle after the edge that consumes the completing bit: latency 1 clock from that edge.
  - out=0 in every other cycle, including cycles with in_valid=0.
- Overlap mode 1: history and fill are kept after a match. Example: "10101" with pattern 101 gives 2 pulses.
- Overlap mode 0: on a match, fill is forced to 0 on the same edge (history bits may remain but are ignored). Example: "10101" with pattern 101 gives 1 pulse; the next match needs L fresh bits.
- in_valid=0: history, fill and out-generation are frozen. out is 0 in the following cycle.
- cfg_load=1 (and rst=0):
  - Latches the new config and clears fill to 0.
  - A simultaneous in_valid bit is discarded, and no match is reported for that edge.
  - cfg_err is updated on the same edge: 1 if cfg_len=0 or cfg_len>MAX_LEN.
  - While cfg_err=1, out stays 0; bits are still shifted and fill still updates.
- L=1 is legal: in overlap mode, every consumed bit equal to pattern[0] pulses out.
- No internal FSM encoding is exposed. The state is defined entirely by the history, fill and latched config.

Optional Feature:
- Macro SEQ_DET_CNT_EN.
- When defined:
  - The match_cnt port exists.
  - It increments by 1 on the same edge that sets out=1 and saturates at all-ones (no wrap).
  - It is cleared by rst and by cfg_load.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset default: rst 2 cycles, then in_valid=1, bits 1,0,1,0,1 → out pulses one cycle after the 3rd and 5th bits; cfg_err=0.
- Non-overlap: cfg_load pattern 'b101, len 3, overlap 0; bits 1,0,1,0,1,0,1 → out pulses after the 3rd and 7th bits only.
- Long pattern with gaps: cfg_load pattern 'b11010011, len 8; stream 11010011 with in_valid deasserted 2 cycles between bits 4 and 5 → single out pulse one cycle after the 8th valid bit; out=0 during the stall.
- Illegal length: cfg_load len 0, then bits 1,1,1 → out stays 0 and cfg_err=1. Then load len 9 with MAX_LEN=8 → cfg_err=1. Then load len 2, pattern 'b11, overlap 1 → cfg_err=0, and bits 1,1,1 produce 2 pulses.
- Collisions: cfg_load on the same edge as the completing bit of a match → no pulse, fill=0. rst asserted when fill=2 of a 3-bit pattern → out=0, fill=0, and the next 3 bits 1,0,1 are needed for a match.
- SEQ_DET_CNT_EN with CNT_W=2, pattern len 1 ('b1), overlap 1: 5 consecutive 1s → match_cnt reads 1,2,3,3,3. cfg_load → match_cnt=0.
